txn_slave_responder: RTL

//  Responder (slave) end of the transactor request/response interface; answers requests issued by the master model.

---
 rtl/txn_slave_responder.sv | 114 +++++++++++
 1 files changed

// File: rtl/txn_slave_responder.sv
`timescale 1ns/1ps
// Responder end of the transactor request/response link: one request in flight, fixed wait states, local word store.
// Optional feature: define TXN_SLV_ERR_EN to flag out-of-range accesses on rsp_err (tied 0 otherwise).
module txn_slave_responder #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]      WAIT_LD   = 8'(WAIT_CYC);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    logic [7:0]        wait_cnt;
    logic              hold_we;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic [IDX_W-1:0]  idx;

    assign in_range = ({1'b0, hold_addr} < DEPTH_LIM);
    assign idx      = hold_addr[IDX_W-1:0];

    // The counter runs WAIT_CYC down to zero; the zero-count cycle is the one whose
    // closing edge performs the storage access and raises rsp_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            wait_cnt   <= '0;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        hold_we    <= req_we;
                        hold_addr  <= req_addr;
                        hold_wdata <= req_wdata;
                        wait_cnt   <= WAIT_LD;
                        req_ready  <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        if (in_range) begin
                            if (hold_we) begin
                                mem[idx]  <= hold_wdata;
                                rsp_rdata <= hold_wdata;
                            end else begin
                                rsp_rdata <= mem[idx];
                            end
                        end else begin
                            rsp_rdata <= '0;
                        end
`ifdef TXN_SLV_ERR_EN
                        rsp_err <= !in_range;
`else
                        rsp_err <= 1'b0;
`endif
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                RESP: begin
                    // rsp_rdata deliberately keeps its value after the handshake
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
